// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the pipeline stage record used by the command master.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_e;

   localparam logic [2:0] HBURST_SINGLE    = 3'b000;
   localparam logic       HRESP_OKAY       = 1'b0;
   localparam logic       HRESP_ERROR      = 1'b1;
   localparam logic [1:0] CMD_SIZE_ILLEGAL = 2'd3;

   // Address field is sized for the widest bus; stages keep only the low AWIDTH bits live.
   localparam int ADDR_MAX_W = 32;

   typedef struct packed {
      logic                  vld;
      logic                  ill;
      logic                  write;
      logic [1:0]            size;
      logic [ADDR_MAX_W-1:0] addr;
      logic [31:0]           wdata;
   } stage_t;

endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// Command/response stream plus AHB-Lite master signals for ahb_lite_cmd_master.
interface ahb_lite_cmd_master_if #(
   parameter int AWIDTH = 10
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [AWIDTH-1:0] cmd_addr;
   logic [1:0]        cmd_size;
   logic [31:0]       cmd_wdata;

   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   logic              HSEL;
   logic [AWIDTH-1:0] HADDR;
   logic              HWRITE;
   logic [1:0]        HTRANS;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic              HMASTLOCK;
   logic [3:0]        HPROT;
   logic [31:0]       HWDATA;
   logic [31:0]       HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTLOCK, HPROT, HWDATA,
      output HRDATA, HREADY, HRESP
   );

endinterface

// File: rtl/ahb_lite_cmd_master.sv
// Valid/ready command stream to AHB-Lite SINGLE transfers with overlapped address (A)
// and data (D) stages, in-order responses, ERROR cancel-and-retry and illegal-size bypass.
module ahb_lite_cmd_master
   import ahb_pkg::*;
#(
   parameter int         AWIDTH    = 10,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input logic                   HCLK,
   input logic                   HRESET,
   ahb_lite_cmd_master_if.master bus
);

   stage_t      a_q, a_d, d_q, d_d, cmd_stage;
   logic        cancel_q, cancel_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        accept;
   logic        issue;

   assign bus.cmd_ready = !HRESET && (!a_q.vld || bus.HREADY) && !cancel_q;
   assign accept        = bus.cmd_valid && bus.cmd_ready;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cmd_stage                   = '0;
      cmd_stage.vld               = 1'b1;
      cmd_stage.ill               = (bus.cmd_size == CMD_SIZE_ILLEGAL);
      cmd_stage.write             = bus.cmd_write;
      cmd_stage.size              = bus.cmd_size;
      cmd_stage.addr[AWIDTH-1:0]  = bus.cmd_addr;
      cmd_stage.wdata             = bus.cmd_wdata;
   end

   always_comb begin
      a_d         = a_q;
      d_d         = d_q;
      cancel_d    = cancel_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      if (bus.HREADY) begin
         cancel_d = 1'b0;
         if (d_q.vld) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (d_q.write || d_q.ill) ? '0 : bus.HRDATA;
            rsp_err_d   = d_q.ill || (bus.HRESP == HRESP_ERROR);
         end
         // A cancelled address phase never reached the bus, so A stays put for a reissue.
         if (cancel_q) begin
            d_d = '0;
         end else begin
            d_d       = a_q;
            a_d.vld   = 1'b0;
         end
      end else if (d_q.vld && !d_q.ill && (bus.HRESP == HRESP_ERROR)) begin
         cancel_d = 1'b1;
      end

      if (accept) begin
         a_d = cmd_stage;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         a_q         <= '0;
         d_q         <= '0;
         cancel_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         a_q         <= a_d;
         d_q         <= d_d;
         cancel_q    <= cancel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign issue = a_q.vld && !a_q.ill && !cancel_q;

   assign bus.HTRANS    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.HSEL      = issue;
   assign bus.HADDR     = a_q.addr[AWIDTH-1:0];
   assign bus.HWRITE    = a_q.write;
   assign bus.HSIZE     = {1'b0, a_q.size};
   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HWDATA    = d_q.wdata;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Directed bench for ahb_lite_cmd_master: the bench plays both command source and AHB slave.
module tb_ahb_lite_cmd_master;
   import ahb_pkg::*;

   localparam int AW = 10;

   logic HCLK = 1'b0;
   logic HRESET;
   int   tests_run    = 0;
   int   tests_failed = 0;

   ahb_lite_cmd_master_if #(.AWIDTH(AW)) bus ();

   ahb_lite_cmd_master #(.AWIDTH(AW), .HPROT_VAL(4'b0011)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #2;
   endtask

   task automatic drive_cmd(input logic v, input logic w, input logic [AW-1:0] a,
                            input logic [1:0] s, input logic [31:0] d);
      bus.cmd_valid = v;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_size  = s;
      bus.cmd_wdata = d;
   endtask

   task automatic drive_slv(input logic rdy, input logic resp, input logic [31:0] rd);
      bus.HREADY = rdy;
      bus.HRESP  = resp;
      bus.HRDATA = rd;
   endtask

   task automatic chk_rdy(input string tag, input logic exp);
      #1;
      check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(exp));
   endtask

   task automatic chk_addr(input string tag, input logic nonseq, input logic [AW-1:0] a,
                           input logic w);
      check({tag, ".htrans"}, 32'(bus.HTRANS), nonseq ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
      check({tag, ".hsel"}, 32'(bus.HSEL), 32'(nonseq));
      if (nonseq) begin
         check({tag, ".haddr"}, 32'(bus.HADDR), 32'(a));
         check({tag, ".hwrite"}, 32'(bus.HWRITE), 32'(w));
      end
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [31:0] rd, input logic e);
      check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(v));
      if (v) begin
         check({tag, ".rsp_rdata"}, bus.rsp_rdata, rd);
         check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(e));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wd;

      // Reset state
      HRESET = 1'b1;
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      tick();
      check("rst.htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
      check("rst.hsel", 32'(bus.HSEL), 32'd0);
      check("rst.haddr", 32'(bus.HADDR), 32'd0);
      check("rst.hwrite", 32'(bus.HWRITE), 32'd0);
      check("rst.hsize", 32'(bus.HSIZE), 32'd0);
      check("rst.hwdata", bus.HWDATA, 32'd0);
      check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst.rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst.hburst", 32'(bus.HBURST), 32'd0);
      check("rst.hmastlock", 32'(bus.HMASTLOCK), 32'd0);
      check("rst.hprot", 32'(bus.HPROT), 32'h3);
      chk_rdy("rst.held", 1'b0);
      HRESET = 1'b0;
      chk_rdy("rst.release", 1'b1);

      // T1: write 0x010 <- DEADBEEF then read it back, zero wait states
      drive_cmd(1'b1, 1'b1, 10'h010, 2'd2, 32'hDEADBEEF);
      chk_rdy("t1.c0", 1'b1);
      tick();
      chk_addr("t1.c1", 1'b1, 10'h010, 1'b1);
      check("t1.c1.hsize", 32'(bus.HSIZE), 32'(HSIZE_WORD));
      drive_cmd(1'b1, 1'b0, 10'h010, 2'd2, 32'h0);
      chk_rdy("t1.c1", 1'b1);
      tick();
      chk_addr("t1.c2", 1'b1, 10'h010, 1'b0);
      check("t1.c2.hwdata", bus.HWDATA, 32'hDEADBEEF);
      chk_rsp("t1.c2", 1'b0, '0, 1'b0);
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      tick();
      chk_addr("t1.c3", 1'b0, '0, 1'b0);
      chk_rsp("t1.c3", 1'b1, 32'h0, 1'b0);
      drive_slv(1'b1, 1'b0, 32'hDEADBEEF);
      tick();
      chk_rsp("t1.c4", 1'b1, 32'hDEADBEEF, 1'b0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      chk_rsp("t1.c5", 1'b0, '0, 1'b0);

      // T2: four back-to-back word writes
      for (int k = 0; k < 6; k++) begin
         wd = 32'(32'h1111_1111 * (k + 1));
         if (k < 4) begin
            drive_cmd(1'b1, 1'b1, 10'(4 * k), 2'd2, wd);
            chk_rdy($sformatf("t2.k%0d", k), 1'b1);
         end else begin
            drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
         end
         tick();
         chk_addr($sformatf("t2.k%0d", k), k < 4, 10'(4 * k), 1'b1);
         if (k >= 1 && k <= 4)
            check($sformatf("t2.k%0d.hwdata", k), bus.HWDATA, 32'(32'h1111_1111 * k));
         chk_rsp($sformatf("t2.k%0d", k), k >= 2, 32'h0, 1'b0);
      end
      tick();
      chk_rsp("t2.end", 1'b0, '0, 1'b0);

      // T3: three reads, three wait states on the second
      drive_cmd(1'b1, 1'b0, 10'h020, 2'd2, '0);
      chk_rdy("t3.c0", 1'b1);
      tick();
      chk_addr("t3.c1", 1'b1, 10'h020, 1'b0);
      drive_cmd(1'b1, 1'b0, 10'h024, 2'd2, '0);
      chk_rdy("t3.c1", 1'b1);
      tick();
      chk_addr("t3.c2", 1'b1, 10'h024, 1'b0);
      drive_slv(1'b1, 1'b0, 32'hA0A0_A0A0);
      drive_cmd(1'b1, 1'b0, 10'h028, 2'd2, '0);
      chk_rdy("t3.c2", 1'b1);
      tick();
      chk_addr("t3.c3", 1'b1, 10'h028, 1'b0);
      chk_rsp("t3.c3", 1'b1, 32'hA0A0_A0A0, 1'b0);
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      drive_slv(1'b0, 1'b0, 32'hFFFF_FFFF);
      chk_rdy("t3.c3.wait", 1'b0);
      for (int w = 4; w <= 5; w++) begin
         tick();
         chk_addr($sformatf("t3.c%0d", w), 1'b1, 10'h028, 1'b0);
         chk_rsp($sformatf("t3.c%0d", w), 1'b0, '0, 1'b0);
         chk_rdy($sformatf("t3.c%0d.wait", w), 1'b0);
      end
      tick();
      chk_addr("t3.c6", 1'b1, 10'h028, 1'b0);
      chk_rsp("t3.c6", 1'b0, '0, 1'b0);
      drive_slv(1'b1, 1'b0, 32'hB1B1_B1B1);
      chk_rdy("t3.c6", 1'b1);
      tick();
      chk_addr("t3.c7", 1'b0, '0, 1'b0);
      chk_rsp("t3.c7", 1'b1, 32'hB1B1_B1B1, 1'b0);
      drive_slv(1'b1, 1'b0, 32'hC2C2_C2C2);
      tick();
      chk_rsp("t3.c8", 1'b1, 32'hC2C2_C2C2, 1'b0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      chk_rsp("t3.c9", 1'b0, '0, 1'b0);

      // T4: ERROR on write to 0x3FC while a read of 0x000 waits in A
      drive_cmd(1'b1, 1'b1, 10'h3FC, 2'd2, 32'h0000_0055);
      chk_rdy("t4.c0", 1'b1);
      tick();
      chk_addr("t4.c1", 1'b1, 10'h3FC, 1'b1);
      drive_cmd(1'b1, 1'b0, 10'h000, 2'd2, '0);
      tick();
      chk_addr("t4.c2", 1'b1, 10'h000, 1'b0);
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      drive_slv(1'b0, 1'b1, '0);
      chk_rdy("t4.c2", 1'b0);
      tick();
      chk_addr("t4.c3", 1'b0, '0, 1'b0);
      check("t4.c3.haddr_kept", 32'(bus.HADDR), 32'h000);
      check("t4.c3.hwdata", bus.HWDATA, 32'h0000_0055);
      chk_rsp("t4.c3", 1'b0, '0, 1'b0);
      drive_slv(1'b1, 1'b1, '0);
      chk_rdy("t4.c3", 1'b0);
      tick();
      chk_rsp("t4.c4", 1'b1, 32'h0, 1'b1);
      chk_addr("t4.c4.retry", 1'b1, 10'h000, 1'b0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      chk_rsp("t4.c5", 1'b0, '0, 1'b0);
      chk_addr("t4.c5", 1'b0, '0, 1'b0);
      drive_slv(1'b1, 1'b0, 32'h0BAD_F00D);
      tick();
      chk_rsp("t4.c6", 1'b1, 32'h0BAD_F00D, 1'b0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      chk_rsp("t4.c7", 1'b0, '0, 1'b0);

      // T5: illegal size between two reads
      drive_cmd(1'b1, 1'b0, 10'h030, 2'd2, '0);
      tick();
      chk_addr("t5.c1", 1'b1, 10'h030, 1'b0);
      drive_cmd(1'b1, 1'b0, 10'h034, 2'd3, '0);
      chk_rdy("t5.c1", 1'b1);
      tick();
      chk_addr("t5.c2.ill", 1'b0, '0, 1'b0);
      drive_slv(1'b1, 1'b0, 32'h0000_0011);
      drive_cmd(1'b1, 1'b0, 10'h038, 2'd2, '0);
      chk_rdy("t5.c2", 1'b1);
      tick();
      chk_addr("t5.c3", 1'b1, 10'h038, 1'b0);
      chk_rsp("t5.c3", 1'b1, 32'h0000_0011, 1'b0);
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      drive_slv(1'b1, 1'b0, 32'hFFFF_FFFF);
      tick();
      chk_addr("t5.c4", 1'b0, '0, 1'b0);
      chk_rsp("t5.c4.ill", 1'b1, 32'h0, 1'b1);
      drive_slv(1'b1, 1'b0, 32'h0000_0022);
      tick();
      chk_rsp("t5.c5", 1'b1, 32'h0000_0022, 1'b0);
      drive_slv(1'b1, 1'b0, '0);
      tick();
      chk_rsp("t5.c6", 1'b0, '0, 1'b0);

      // T6: reset during a wait state with two commands in flight
      drive_cmd(1'b1, 1'b1, 10'h040, 2'd2, 32'h0000_0077);
      tick();
      drive_cmd(1'b1, 1'b0, 10'h044, 2'd2, '0);
      tick();
      chk_addr("t6.c2", 1'b1, 10'h044, 1'b0);
      drive_cmd(1'b0, 1'b0, '0, 2'd0, '0);
      drive_slv(1'b0, 1'b0, '0);
      tick();
      chk_addr("t6.c3.wait", 1'b1, 10'h044, 1'b0);
      check("t6.c3.hwdata", bus.HWDATA, 32'h0000_0077);
      HRESET = 1'b1;
      chk_rdy("t6.c3.rst", 1'b0);
      tick();
      chk_addr("t6.c4", 1'b0, '0, 1'b0);
      check("t6.c4.hwdata", bus.HWDATA, 32'h0);
      chk_rsp("t6.c4", 1'b0, '0, 1'b0);
      HRESET = 1'b0;
      drive_slv(1'b1, 1'b0, '0);
      chk_rdy("t6.c4.release", 1'b1);
      tick();
      chk_rsp("t6.c5", 1'b0, '0, 1'b0);
      chk_addr("t6.c5", 1'b0, '0, 1'b0);
      tick();
      chk_rsp("t6.c6", 1'b0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- Upstream stage for the AHB slave BFM.
- Converts a simple valid/ready command stream (read/write, address, data, size) into AHB-Lite SINGLE transfers.
- Address and data phases are pipelined, so back-to-back commands overlap.
- Returns read data and error status on a response strobe; used to drive the BFM slave and GPIO register blocks in block-level benches.

Parameters:
- AWIDTH, 10, width of HADDR and cmd_addr.
- HPROT_VAL, 4'b0011, constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).

Ports:
- HCLK  in  1  single clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AWIDTH  byte address.
- cmd_size  in  2  HSIZE[1:0]: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse, one per accepted command, in command order.
- rsp_rdata  out  32  HRDATA captured for reads; 0 for writes.
- rsp_err  out  1  transfer ended with HRESP=ERROR, or command was illegal.
- HSEL  out  1  high while an address phase is driven.
- HADDR  out  AWIDTH  address-phase address.
- HWRITE  out  1  address-phase direction.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HSIZE  out  3  {1'b0, cmd_size}.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HMASTLOCK  out  1  constant 0.
- HPROT  out  4  constant HPROT_VAL.
- HWDATA  out  32  data-phase write data.
- HRDATA  in  32  slave read data.
- HREADY  in  1  slave ready; also fed to the slave's HREADYIN.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (HRESET=1 at edge):
  - HTRANS=00, HSEL=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Address and data stages are emptied.
  - cmd_ready forced 0 while HRESET=1.
- Reset mid-transfer discards in-flight commands with no response. The slave is reset by the same reset.
- Two stages:
  - A (address phase): a_vld, a_addr, a_write, a_size, a_wdata.
  - D (data phase): d_vld, d_write, d_wdata.
  - HTRANS=NONSEQ and HSEL=1 iff a_vld and no error cancel is active; otherwise IDLE/0.
  - HADDR, HWRITE and HSIZE come from stage A; HWDATA comes from stage D and is held until D completes.
- Advance: on an edge with HREADY=1:
  - D completes; if d_vld, rsp_valid pulses the next cycle.
  - For reads, rsp_rdata = HRDATA sampled at that edge.
  - rsp_err = HRESP sampled at that edge.
  - A moves into D; an accepted command loads A.
- cmd_ready = !HRESET && (!a_vld || HREADY) && !cancel. It is combinational on HREADY.
- Latency: command accepted at edge N → NONSEQ on cycle N+1 → response pulse on cycle N+3 with zero wait states.
- Throughput: one transfer per cycle sustained.
- Wait states (HREADY=0): A, D, HADDR and HWDATA are all held stable. No acceptance is possible while a_vld.
- ERROR response, cycle 1 (HRESP=1, HREADY=0):
  - The next cycle is cancel: HTRANS=IDLE, HSEL=0.
  - The A contents are retained, not dropped.
- ERROR response, cycle 2 (HRESP=1, HREADY=1):
  - D completes with rsp_err=1.
  - The retained A command moves to D only in the following cycle. It is reissued as NONSEQ first (AHB-Lite cancel-and-retry option).
- Illegal cmd_size=3:
  - The command is accepted but no bus transfer is issued.
  - Its response (rsp_err=1, rdata=0) is emitted in order, once all earlier commands have responded.
  - Implement by carrying an ill flag through A/D that gates HTRANS to IDLE.
- Alignment: the address is not checked; cmd_addr is passed as-is.
- Responses have no backpressure; the consumer samples every rsp_valid pulse.
- Simultaneous events: acceptance at the same edge D completes and A advances is legal, which gives a full pipeline.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE_BYTE/HALF/WORD.
  - HBURST_SINGLE, HRESP_OKAY/ERROR.
  - A stage-record typedef (vld, ill, write, size, addr, wdata).
- Single module; no sub-module. Both stages use the same record type.

Test Plan:
- Write 0x0000_0010 ← 0xDEADBEEF, then read 0x010, zero wait states → NONSEQ write then read on consecutive cycles; HWDATA=0xDEADBEEF one cycle after write address; read response rdata=0xDEADBEEF, err=0; two rsp pulses in order.
- 4 back-to-back word writes (0x00..0x0C) with cmd_valid held high → HTRANS=NONSEQ for 4 consecutive cycles; cmd_ready stays 1; 4 responses on consecutive cycles.
- Slave inserts 3 wait states on the 2nd of 3 reads → HADDR/HWDATA stable for 3 cycles; cmd_ready=0 during the wait; responses still in order with correct data.
- Slave returns ERROR on write to 0x3FC while a read of 0x000 sits in A → cycle-2 HTRANS=IDLE; write rsp_err=1; read of 0x000 reissued as NONSEQ and returns err=0.
- cmd_size=3 issued between two valid reads → no NONSEQ for it; three responses in order, middle one err=1, rdata=0.
- HRESET asserted during a wait state with 2 commands in flight → next cycle HTRANS=IDLE; no rsp_valid for the dropped commands; cmd_ready=1 the cycle after reset deasserts.
